// File: rtl/ws2812_frame_sender_pkg.sv
// Shared definitions for the WS2812 frame sender: FSM state encoding and default strip timing.
package ws2812_frame_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    // Defaults assume a 50 MHz clk_sys-style clock.
    localparam int DEF_MAX_POS      = 16;
    localparam int DEF_T0H_CYCLES   = 20;
    localparam int DEF_T1H_CYCLES   = 40;
    localparam int DEF_BIT_CYCLES   = 63;
    localparam int DEF_RESET_CYCLES = 2600;

endpackage

// File: rtl/ws2812_frame_sender_if.sv
// Link between display_unit (master) and the frame sender (slave).
interface ws2812_frame_sender_if #(
    parameter int MAX_POS = 16
);
    localparam int LEDW = $clog2(MAX_POS);

    logic            update_frame;
    logic [7:0]      led_green_intensity;
    logic [7:0]      led_red_intensity;
    logic [7:0]      led_blue_intensity;
    logic [LEDW-1:0] current_led;
    logic            data_out;
    logic            busy;
    logic            frame_done;

    modport master (
        output update_frame, led_green_intensity, led_red_intensity, led_blue_intensity,
        input  current_led, data_out, busy, frame_done
    );

    modport slave (
        input  update_frame, led_green_intensity, led_red_intensity, led_blue_intensity,
        output current_led, data_out, busy, frame_done
    );

endinterface

// File: rtl/ws2812_bit_encoder.sv
// Generates one WS2812 bit waveform: high for T0H/T1H cycles, low for the rest of BIT_CYCLES.
module ws2812_bit_encoder
    import ws2812_frame_sender_pkg::*;
#(
    parameter int T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic en_i,
    input  logic bit_i,
    output logic data_o,
    output logic bit_last_o
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H_CYCLES);

    logic [CW-1:0] bit_cnt_q, bit_cnt_d;

    assign bit_last_o = en_i && (bit_cnt_q == CNT_LAST);
    assign data_o     = en_i && (bit_cnt_q < (bit_i ? T1H_C : T0H_C));

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (start_i) begin
            bit_cnt_d = '0;
        end else if (en_i) begin
            bit_cnt_d = bit_last_o ? '0 : bit_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/ws2812_frame_sender.sv
// Walks LEDs 0..MAX_POS-1, serialises their GRB bytes MSB-first, then holds the line low to latch.
//   state    | meaning
//   ST_IDLE  | line low, waiting for a frame request
//   ST_LOAD  | capture {G,R,B} for current_led (one cycle)
//   ST_SEND  | shift 24 bits out through the bit encoder
//   ST_LATCH | line low for RESET_CYCLES, frame_done on the last cycle
module ws2812_frame_sender
    import ws2812_frame_sender_pkg::*;
#(
    parameter int MAX_POS      = DEF_MAX_POS,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    ws2812_frame_sender_if.slave  bus
);
    localparam int LEDW = $clog2(MAX_POS);
    localparam int LW   = $clog2(RESET_CYCLES);
    localparam logic [LEDW-1:0] LED_LAST = LEDW'(MAX_POS - 1);
    localparam logic [LW-1:0]   LAT_LAST = LW'(RESET_CYCLES - 1);

    state_e          state_q, state_d;
    logic            pending_q, pending_d;
    logic [23:0]     shreg_q, shreg_d;
    logic [4:0]      bit_idx_q, bit_idx_d;
    logic [LEDW-1:0] led_q, led_d;
    logic [LW-1:0]   lat_cnt_q, lat_cnt_d;

    logic enc_start, enc_en, enc_last, enc_data;
    logic frame_done_c;

    ws2812_bit_encoder #(
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_encoder (
        .clk        (clk),
        .reset      (reset),
        .start_i    (enc_start),
        .en_i       (enc_en),
        .bit_i      (shreg_q[23]),
        .data_o     (enc_data),
        .bit_last_o (enc_last)
    );

    always_comb begin
        state_d      = state_q;
        // Requests arriving mid-frame collapse into a single follow-on frame.
        pending_d    = pending_q | bus.update_frame;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        led_d        = led_q;
        lat_cnt_d    = lat_cnt_q;
        enc_start    = 1'b0;
        enc_en       = 1'b0;
        frame_done_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q || bus.update_frame) begin
                    led_d     = '0;
                    pending_d = 1'b0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d   = {bus.led_green_intensity, bus.led_red_intensity, bus.led_blue_intensity};
                bit_idx_d = 5'd23;
                enc_start = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                enc_en = 1'b1;
                if (enc_last) begin
                    shreg_d   = {shreg_q[22:0], 1'b0};
                    bit_idx_d = bit_idx_q - 5'd1;
                    if (bit_idx_q == 5'd0) begin
                        if (led_q == LED_LAST) begin
                            lat_cnt_d = '0;
                            state_d   = ST_LATCH;
                        end else begin
                            led_d   = led_q + LEDW'(1);
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (lat_cnt_q == LAT_LAST) begin
                    frame_done_c = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            led_q     <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            led_q     <= led_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign bus.current_led = led_q;
    assign bus.data_out    = enc_data;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.frame_done  = frame_done_c;

endmodule

// File: tb/tb_ws2812_frame_sender.sv
// Directed bench for ws2812_frame_sender with a 4-LED strip and a shortened latch period.
module tb_ws2812_frame_sender;

    localparam int MAXP         = 4;
    localparam int RST_CYC      = 100;
    localparam int T0H          = 20;
    localparam int T1H          = 40;
    localparam int BITC         = 63;
    localparam int LED_SLOT     = 24 * BITC + 1;               // 1513
    localparam int FRAME_BUSY   = MAXP * LED_SLOT + RST_CYC;   // 6152 cycles LOAD..last LATCH
    localparam int FRAME_PERIOD = FRAME_BUSY + 1;              // 6153 incl. one IDLE cycle

    typedef struct {
        logic [3:0][7:0]  g;
        logic [3:0][7:0]  r;
        logic [3:0][7:0]  b;
        logic [3:0][23:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0][23:0] words;
        int nbits;
        int bad_w;
        int busy_cyc;
        int wait_n;
        int first_hi;
        int start_cyc;
        bit tmo;
    } cap_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    logic [3:0][7:0] tbl_g, tbl_r, tbl_b;
    logic [7:0]      mask;
    vec_t            vecs[3];
    cap_t            ca, cb;
    bit              ok;
    int              cnt;

    ws2812_frame_sender_if #(.MAX_POS(MAXP)) ifc ();

    assign ifc.led_green_intensity = tbl_g[ifc.current_led] ^ mask;
    assign ifc.led_red_intensity   = tbl_r[ifc.current_led] ^ mask;
    assign ifc.led_blue_intensity  = tbl_b[ifc.current_led] ^ mask;

    ws2812_frame_sender #(
        .MAX_POS      (MAXP),
        .T0H_CYCLES   (T0H),
        .T1H_CYCLES   (T1H),
        .BIT_CYCLES   (BITC),
        .RESET_CYCLES (RST_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic pulse_update();
        @(negedge clk);
        ifc.update_frame = 1'b1;
        @(negedge clk);
        ifc.update_frame = 1'b0;
    endtask

    task automatic load_vec(input int v);
        tbl_g = vecs[v].g;
        tbl_r = vecs[v].r;
        tbl_b = vecs[v].b;
    endtask

    // Decodes one frame from data_out pulse widths, from busy rise through frame_done.
    task automatic capture_frame(output cap_t c);
        int run;
        bit seen_hi;
        bit b;
        c.words = '0; c.nbits = 0; c.bad_w = 0; c.busy_cyc = 0;
        c.wait_n = 0; c.first_hi = -1; c.start_cyc = 0; c.tmo = 1'b0;
        run = 0; seen_hi = 1'b0;
        do begin
            @(negedge clk);
            c.wait_n++;
        end while (!ifc.busy && c.wait_n < 40);
        if (!ifc.busy) begin c.tmo = 1'b1; return; end
        c.start_cyc = cyc;
        for (int n = 0; n < FRAME_BUSY + 50; n++) begin
            if (n > 0) @(negedge clk);
            if (!ifc.busy) begin c.tmo = 1'b1; return; end
            c.busy_cyc++;
            if (ifc.data_out) begin
                run++;
                if (!seen_hi) begin seen_hi = 1'b1; c.first_hi = n; end
            end else if (run > 0) begin
                b = (run == T1H);
                if (run != T1H && run != T0H) c.bad_w++;
                if (c.nbits < 96) c.words[c.nbits / 24] = {c.words[c.nbits / 24][22:0], b};
                c.nbits++;
                run = 0;
            end
            if (ifc.frame_done) return;
        end
        c.tmo = 1'b1;
    endtask

    task automatic check_frame(input string tag, input cap_t c, input logic [3:0][23:0] exp);
        check({tag, " timeout"}, 32'(c.tmo), 32'd0);
        check({tag, " bit count"}, c.nbits, 96);
        check({tag, " bad pulse widths"}, c.bad_w, 0);
        check({tag, " busy length"}, c.busy_cyc, FRAME_BUSY);
        check({tag, " first rise offset"}, c.first_hi, 1);
        for (int k = 0; k < MAXP; k++)
            check($sformatf("%s led%0d word", tag, k), 32'(c.words[k]), 32'(exp[k]));
    endtask

    task automatic wait_led_high(input int led, output bit found);
        found = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (ifc.current_led == 2'(led) && ifc.data_out) begin found = 1'b1; return; end
        end
    endtask

    initial begin
        vecs[0].g = '0; vecs[0].r = '0; vecs[0].b = '0; vecs[0].exp = '0;
        vecs[1].g   = {8'h00, 8'h80, 8'hFF, 8'h12};
        vecs[1].r   = {8'hFF, 8'h01, 8'h00, 8'h34};
        vecs[1].b   = {8'h00, 8'hA5, 8'hFF, 8'h56};
        vecs[1].exp = {24'h00FF00, 24'h8001A5, 24'hFF00FF, 24'h123456};
        vecs[2].g   = {8'h7E, 8'hFF, 8'hAA, 8'h01};
        vecs[2].r   = {8'h81, 8'hFF, 8'h55, 8'h02};
        vecs[2].b   = {8'h3C, 8'hFF, 8'hF0, 8'h03};
        vecs[2].exp = {24'h7E813C, 24'hFFFFFF, 24'hAA55F0, 24'h010203};

        reset = 1'b1;
        ifc.update_frame = 1'b0;
        mask = 8'h00;
        load_vec(0);
        repeat (3) @(negedge clk);
        check("reset data_out", 32'(ifc.data_out), 32'd0);
        check("reset busy", 32'(ifc.busy), 32'd0);
        check("reset frame_done", 32'(ifc.frame_done), 32'd0);
        check("reset current_led", 32'(ifc.current_led), 32'd0);
        reset = 1'b0;
        cnt = 0;
        repeat (10) begin @(negedge clk); cnt += int'(ifc.busy); end
        check("idle without request", cnt, 0);

        // Table-driven frames: all-zero strip, index-dependent data, mixed data.
        for (int v = 0; v < 3; v++) begin
            load_vec(v);
            fork
                capture_frame(ca);
                pulse_update();
            join
            check_frame($sformatf("vec%0d", v), ca, vecs[v].exp);
            @(negedge clk);
            check($sformatf("vec%0d busy after", v), 32'(ifc.busy), 32'd0);
            check($sformatf("vec%0d done width", v), 32'(ifc.frame_done), 32'd0);
        end

        // Three requests during LED 1 coalesce into exactly one follow-on frame.
        load_vec(2);
        fork
            capture_frame(ca);
            begin
                pulse_update();
                wait_led_high(1, ok);
                check("coalesce reach led1", 32'(ok), 32'd1);
                repeat (100) @(negedge clk);
                repeat (3) begin
                    pulse_update();
                    repeat (40) @(negedge clk);
                end
            end
        join
        capture_frame(cb);
        check_frame("coalesce A", ca, vecs[2].exp);
        check_frame("coalesce B", cb, vecs[2].exp);
        check("coalesce restart gap", cb.wait_n, 2);
        cnt = 0;
        repeat (300) begin @(negedge clk); cnt += int'(ifc.busy); end
        check("coalesce no third frame", cnt, 0);

        // Asynchronous reset in the middle of a bit on LED 2.
        load_vec(1);
        pulse_update();
        wait_led_high(2, ok);
        check("reset-mid reach led2", 32'(ok), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("reset-mid data_out", 32'(ifc.data_out), 32'd0);
        check("reset-mid busy", 32'(ifc.busy), 32'd0);
        check("reset-mid current_led", 32'(ifc.current_led), 32'd0);
        cnt = 0;
        repeat (5) begin @(negedge clk); cnt += int'(ifc.frame_done); end
        reset = 1'b0;
        repeat (20) begin @(negedge clk); cnt += int'(ifc.frame_done) + int'(ifc.busy); end
        check("reset-mid no done or restart", cnt, 0);
        fork
            capture_frame(ca);
            pulse_update();
        join
        check_frame("after reset", ca, vecs[1].exp);

        // update_frame held high: back-to-back frames with one IDLE cycle between.
        load_vec(2);
        @(negedge clk);
        ifc.update_frame = 1'b1;
        capture_frame(ca);
        capture_frame(cb);
        ifc.update_frame = 1'b0;
        reset = 1'b1;
        check_frame("held A", ca, vecs[2].exp);
        check_frame("held B", cb, vecs[2].exp);
        check("held idle gap", cb.wait_n, 2);
        check("held frame period", cb.start_cyc - ca.start_cyc, FRAME_PERIOD);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin @(negedge clk); cnt += int'(ifc.busy); end
        check("reset clears pending", cnt, 0);

        // Intensities scrambled every cycle except the LOAD cycle of each LED.
        load_vec(1);
        fork
            capture_frame(ca);
            begin
                @(negedge clk);
                ifc.update_frame = 1'b1;
                mask = 8'hFF;
                for (int j = 1; j <= MAXP * LED_SLOT + 2; j++) begin
                    @(negedge clk);
                    if (j == 1) ifc.update_frame = 1'b0;
                    if ((j - 1) % LED_SLOT == 0 && (j - 1) < MAXP * LED_SLOT) mask = 8'h00;
                    else mask = j[0] ? 8'hFF : 8'h5A;
                end
                mask = 8'h00;
            end
        join
        check_frame("scramble", ca, vecs[1].exp);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
